// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a fifo_param instance and its producer/consumer.
// The master modport is the user side; the slave modport is the FIFO itself.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  push;
  logic                  pop;
  logic                  clear;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data_in, push, pop, clear,
    input  data_out, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  data_in, push, pop, clear,
    output data_out, valid, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO: 1-cycle registered read (FWFT=0) or fall-through head (FWFT=1).
// Full rejects push unless a pop is accepted on the same edge; rejects set sticky overflow/underflow.
module fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input logic        clock,
  input logic        reset,
  fifo_param_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_THRESH);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t front_q, front_d;
  ptr_t rear_q, rear_d;
  cnt_t count_q, count_d;
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;
  logic empty, full, pop_ok, push_ok, wr_en;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    pop_ok  = bus.pop & ~empty;
    push_ok = bus.push & (~full | pop_ok);
    front_d = front_q;
    rear_d  = rear_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    // clear wins over everything on its edge, including error reporting
    if (bus.clear) begin
      front_d = '0;
      rear_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      wr_en = push_ok;
      if (pop_ok)  front_d = front_q + ptr_t'(1);
      if (push_ok) rear_d  = rear_q + ptr_t'(1);
      if (push_ok & ~pop_ok)      count_d = count_q + cnt_t'(1);
      else if (pop_ok & ~push_ok) count_d = count_q - cnt_t'(1);
      if (bus.push & ~push_ok) ovf_d = 1'b1;
      if (bus.pop & ~pop_ok)   unf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      front_q <= '0;
      rear_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      front_q <= front_d;
      rear_q  <= rear_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset; the gate keeps a push held through reset from landing.
  always_ff @(posedge clock) begin
    if (wr_en && reset) mem_q[rear_q] <= bus.data_in;
  end

  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.count        = count_q;
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  if (FWFT != 0) begin : g_fwft
    assign bus.data_out = empty ? '0 : mem_q[front_q];
    assign bus.valid    = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;

    always_comb begin
      dout_d  = dout_q;
      valid_d = 1'b0;
      if (!bus.clear && pop_ok) begin
        dout_d  = mem_q[front_q];
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
      end
    end

    assign bus.data_out = dout_q;
    assign bus.valid    = valid_q;
  end
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench: a standard-mode and an FWFT instance (DEPTH 4) against a queue model.
// Popped words are pushed to a scoreboard when driven and compared when the DUT presents them.
module tb_fifo_param;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bs ();
  fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bf ();

  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1))
    u_std (.clock(clock), .reset(reset), .bus(bs));
  fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1))
    u_fw (.clock(clock), .reset(reset), .bus(bf));

  always #5 clock = ~clock;

  // standard-instance model
  int         cnt_s = 0;
  bit         ovf_s = 0, unf_s = 0, vld_s = 0;
  logic [7:0] mq_s[$];
  logic [7:0] sb_s[$];
  // FWFT-instance model
  int         cnt_f = 0;
  bit         ovf_f = 0, unf_f = 0;
  logic [7:0] mq_f[$];

  task automatic cyc_s(input bit p, input bit q, input bit c, input logic [7:0] d);
    bit pok, wok;
    @(negedge clock);
    bs.push = p; bs.pop = q; bs.clear = c; bs.data_in = d;
    if (c) begin
      mq_s.delete(); cnt_s = 0; ovf_s = 0; unf_s = 0; vld_s = 0;
    end else begin
      pok = q && (cnt_s != 0);
      wok = p && ((cnt_s != 4) || pok);
      vld_s = pok;
      if (pok) sb_s.push_back(mq_s.pop_front());
      if (wok) mq_s.push_back(d);
      if (wok && !pok) cnt_s++;
      else if (pok && !wok) cnt_s--;
      if (p && !wok) ovf_s = 1;
      if (q && !pok) unf_s = 1;
    end
    @(posedge clock); #1;
    bs.push = 0; bs.pop = 0; bs.clear = 0;
  endtask

  task automatic cyc_f(input bit p, input bit q, input bit c, input logic [7:0] d);
    bit pok, wok;
    @(negedge clock);
    bf.push = p; bf.pop = q; bf.clear = c; bf.data_in = d;
    if (c) begin
      mq_f.delete(); cnt_f = 0; ovf_f = 0; unf_f = 0;
    end else begin
      pok = q && (cnt_f != 0);
      wok = p && ((cnt_f != 4) || pok);
      if (pok) void'(mq_f.pop_front());
      if (wok) mq_f.push_back(d);
      if (wok && !pok) cnt_f++;
      else if (pok && !wok) cnt_f--;
      if (p && !wok) ovf_f = 1;
      if (q && !pok) unf_f = 1;
    end
    @(posedge clock); #1;
    bf.push = 0; bf.pop = 0; bf.clear = 0;
  endtask

  task automatic test_reset();
    bs.push = 1; bs.pop = 0; bs.clear = 0; bs.data_in = 8'hAA;
    bf.push = 1; bf.pop = 0; bf.clear = 0; bf.data_in = 8'hAB;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (bs.count !== 3'd0 || bf.count !== 3'd0) begin n_err++;
      $display("FAIL reset_count: std=%0d fw=%0d want 0", bs.count, bf.count); end
    n_cmp++; if ({bs.empty, bs.full, bs.almost_empty, bs.almost_full} !== 4'b1010) begin n_err++;
      $display("FAIL reset_flags_std: e/f/ae/af=%b want 1010", {bs.empty, bs.full, bs.almost_empty, bs.almost_full}); end
    n_cmp++; if ({bf.empty, bf.full, bf.almost_empty, bf.almost_full} !== 4'b1010) begin n_err++;
      $display("FAIL reset_flags_fw: e/f/ae/af=%b want 1010", {bf.empty, bf.full, bf.almost_empty, bf.almost_full}); end
    n_cmp++; if ({bs.overflow, bs.underflow, bs.valid, bf.overflow, bf.underflow, bf.valid} !== 6'b0) begin n_err++;
      $display("FAIL reset_ovf_unf_vld: %b want 000000", {bs.overflow, bs.underflow, bs.valid, bf.overflow, bf.underflow, bf.valid}); end
    n_cmp++; if (bs.data_out !== 8'h00 || bf.data_out !== 8'h00) begin n_err++;
      $display("FAIL reset_data: std=%h fw=%h want 00", bs.data_out, bf.data_out); end
    @(negedge clock);
    reset = 1'b1; bs.push = 0; bf.push = 0;
    // nothing may have been stored while reset was held
    cyc_s(0, 1, 0, 8'h00);
    n_cmp++; if (bs.underflow !== 1'b1 || bs.valid !== 1'b0 || bs.count !== 3'd0) begin n_err++;
      $display("FAIL reset_nostore: unf=%b vld=%b cnt=%0d want 1 0 0", bs.underflow, bs.valid, bs.count); end
    cyc_s(0, 0, 1, 8'h00);
    n_cmp++; if (bs.underflow !== 1'b0) begin n_err++;
      $display("FAIL reset_clear_unf: got %b want 0", bs.underflow); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 5; i++) begin
      cyc_s(1, 0, 0, 8'(i));
      n_cmp++; if (bs.count !== 3'(cnt_s)) begin n_err++;
        $display("FAIL fill_count[%0d]: got %0d want %0d", i, bs.count, cnt_s); end
      n_cmp++; if (bs.almost_full !== (cnt_s >= 3) || bs.full !== (cnt_s == 4)) begin n_err++;
        $display("FAIL fill_af_full[%0d]: af=%b full=%b want %b %b", i, bs.almost_full, bs.full, cnt_s >= 3, cnt_s == 4); end
      n_cmp++; if (bs.overflow !== ovf_s) begin n_err++;
        $display("FAIL fill_overflow[%0d]: got %b want %b", i, bs.overflow, ovf_s); end
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) begin
      cyc_s(0, 1, 0, 8'h00);
      n_cmp++; if (bs.valid !== vld_s) begin n_err++;
        $display("FAIL drain_valid[%0d]: got %b want %b", i, bs.valid, vld_s); end
      if (vld_s) begin
        exp = sb_s.pop_front();
        n_cmp++; if (bs.data_out !== exp) begin n_err++;
          $display("FAIL drain_data[%0d]: got %h want %h", i, bs.data_out, exp); end
      end
    end
    n_cmp++; if ({bs.underflow, bs.empty, bs.almost_empty} !== 3'b111) begin n_err++;
      $display("FAIL drain_end: unf/empty/ae=%b want 111", {bs.underflow, bs.empty, bs.almost_empty}); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    cyc_s(0, 0, 1, 8'h00);
    for (int i = 0; i < 7; i++) begin
      cyc_s(1, (i >= 3 && i < 6), 0, 8'h10 + 8'(i));
      n_cmp++; if (bs.count !== 3'(cnt_s) || bs.valid !== vld_s) begin n_err++;
        $display("FAIL wrap_cnt_vld[%0d]: cnt=%0d vld=%b want %0d %b", i, bs.count, bs.valid, cnt_s, vld_s); end
      if (vld_s) begin
        exp = sb_s.pop_front();
        n_cmp++; if (bs.data_out !== exp) begin n_err++;
          $display("FAIL wrap_data[%0d]: got %h want %h", i, bs.data_out, exp); end
      end
    end
    n_cmp++; if (bs.full !== 1'b1) begin n_err++;
      $display("FAIL wrap_full: got %b want 1", bs.full); end
  endtask

  task automatic test_simul();
    logic [7:0] exp;
    cyc_s(1, 1, 0, 8'h20);
    n_cmp++; if (bs.count !== 3'd4 || bs.overflow !== 1'b0 || bs.valid !== 1'b1) begin n_err++;
      $display("FAIL simul_full: cnt=%0d ovf=%b vld=%b want 4 0 1", bs.count, bs.overflow, bs.valid); end
    exp = sb_s.pop_front();
    n_cmp++; if (bs.data_out !== exp) begin n_err++;
      $display("FAIL simul_data: got %h want %h", bs.data_out, exp); end
    for (int i = 0; i < 4; i++) begin
      cyc_s(0, 1, 0, 8'h00);
      exp = sb_s.pop_front();
      n_cmp++; if (bs.valid !== 1'b1 || bs.data_out !== exp) begin n_err++;
        $display("FAIL simul_drain[%0d]: vld=%b data=%h want 1 %h", i, bs.valid, bs.data_out, exp); end
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp;
    cyc_s(0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cyc_s(1, 0, 0, 8'h30 + 8'(i));
    cyc_s(0, 1, 0, 8'h00);
    exp = sb_s.pop_front();
    n_cmp++; if (bs.count !== 3'd3 || bs.overflow !== 1'b1 || bs.data_out !== exp) begin n_err++;
      $display("FAIL flush_pre: cnt=%0d ovf=%b data=%h want 3 1 %h", bs.count, bs.overflow, bs.data_out, exp); end
    cyc_s(1, 0, 1, 8'h99);
    n_cmp++; if (bs.count !== 3'd0 || {bs.empty, bs.overflow, bs.valid} !== 3'b100) begin n_err++;
      $display("FAIL flush_post: cnt=%0d e/ovf/vld=%b want 0 100", bs.count, {bs.empty, bs.overflow, bs.valid}); end
    cyc_s(1, 0, 0, 8'h77);
    cyc_s(0, 1, 0, 8'h00);
    exp = sb_s.pop_front();
    n_cmp++; if (bs.valid !== 1'b1 || bs.data_out !== exp || bs.count !== 3'd0) begin n_err++;
      $display("FAIL flush_discard: vld=%b data=%h cnt=%0d want 1 %h 0", bs.valid, bs.data_out, bs.count, exp); end
  endtask

  task automatic test_fwft();
    cyc_f(1, 0, 0, 8'hFA);
    n_cmp++; if (bf.valid !== 1'b1 || bf.data_out !== mq_f[0]) begin n_err++;
      $display("FAIL fwft_show: vld=%b data=%h want 1 %h", bf.valid, bf.data_out, mq_f[0]); end
    cyc_f(0, 0, 0, 8'h00);
    n_cmp++; if (bf.valid !== 1'b1 || bf.data_out !== mq_f[0]) begin n_err++;
      $display("FAIL fwft_hold: vld=%b data=%h want 1 %h", bf.valid, bf.data_out, mq_f[0]); end
    cyc_f(0, 1, 0, 8'h00);
    n_cmp++; if (bf.valid !== 1'b0 || bf.empty !== 1'b1) begin n_err++;
      $display("FAIL fwft_pop: vld=%b empty=%b want 0 1", bf.valid, bf.empty); end
    cyc_f(1, 1, 0, 8'h3C);
    n_cmp++; if (bf.underflow !== unf_f || bf.count !== 3'(cnt_f) || bf.data_out !== mq_f[0] || bf.valid !== 1'b1) begin n_err++;
      $display("FAIL fwft_empty_pushpop: unf=%b cnt=%0d data=%h vld=%b want %b %0d %h 1",
               bf.underflow, bf.count, bf.data_out, bf.valid, unf_f, cnt_f, mq_f[0]); end
    cyc_f(0, 1, 0, 8'h00);
    n_cmp++; if (bf.valid !== 1'b0 || bf.count !== 3'(cnt_f) || bf.overflow !== ovf_f) begin n_err++;
      $display("FAIL fwft_final: vld=%b cnt=%0d ovf=%b want 0 %0d %b", bf.valid, bf.count, bf.overflow, cnt_f, ovf_f); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simul();
    test_flush();
    test_fwft();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
